fpu_issue_seq: RTL and testbench
================================

FPU_ISSUE_SEQ -- requirements
Module: fpu_issue_seq

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_l  input  1  reset, synchronous and active-high (asserted = 1, sampled on clk).
REQ-003 SHALL have port: fetch_instr  input  32  instruction word from fetch.
REQ-004 SHALL have port: fetch_valid  input  1  fetch_instr valid; push occurs when fetch_valid & fetch_ready.
REQ-005 SHALL have port: fetch_ready  output  1  buffer can accept one word this cycle.
REQ-006 SHALL have port: Instruction  output  32  word presented to decode stage.
REQ-007 SHALL have port: fpu_active  output  1  presented word is a floating-point instruction in flight.
REQ-008 SHALL have port: fpu_complete  input  1  FPU finished current FP instruction.
REQ-009 SHALL have port: halt_req  input  1  decode requests issue pause.
REQ-010 SHALL have port: illegal_config  input  1  decode rejected current FP instruction.
REQ-011 SHALL have port: fpu_timeout  output  1  one-cycle pulse on FP wait abort.
REQ-012 SHALL have port: issue_count  output  16  count of instructions issued, wraps at 16'hFFFF -> 0.

Function
REQ-013 SHALL buffer fetched words in a 4-entry FIFO; fetch_ready = not full; push when full SHALL NOT occur.
REQ-014 SHALL classify a word as FP when opcode [6:0] is 0000111, 0100111, 1000011, 1000111, 1001011, 1001111 or 1010011; as CSR when 1110011.
REQ-015 SHALL implement FSM states IDLE, ISSUE, FPU_WAIT, CSR_GAP, HALT.
REQ-016 IDLE: Instruction = NOP (32'h00000013); leave to ISSUE when FIFO non-empty and halt_req = 0.
REQ-017 ISSUE: present FIFO head for exactly one cycle, pop it, increment issue_count; next state FPU_WAIT if FP, CSR_GAP if CSR, else ISSUE if FIFO non-empty after pop, else IDLE.
REQ-018 FPU_WAIT: hold the FP word on Instruction, fpu_active = 1; fpu_complete SHALL be sampled only in this state (ignored elsewhere).
REQ-019 FPU_WAIT exit on fpu_complete = 1 -> ISSUE or IDLE per FIFO occupancy; fpu_active drops the following cycle.
REQ-020 FPU_WAIT exit on illegal_config = 1 (priority over fpu_complete) -> same target, no timeout pulse.
REQ-021 FPU_WAIT SHALL run an 8-bit wait counter cleared on entry; on reaching 255 with no completion, pulse fpu_timeout for one cycle and exit as REQ-019.
REQ-022 CSR_GAP: present NOP for exactly one cycle (covers registered CSR read-back), then ISSUE/IDLE per occupancy.
REQ-023 halt_req = 1 in IDLE or ISSUE-decision point SHALL enter HALT instead of ISSUE; HALT presents NOP, no pop, exits to ISSUE/IDLE when halt_req = 0; halt_req SHALL NOT interrupt FPU_WAIT or CSR_GAP.
REQ-024 Push and pop in the same cycle SHALL both succeed; occupancy unchanged; pointers wrap modulo 4 with an extra wrap bit for full/empty.
REQ-025 fpu_active SHALL be 0 in every state except FPU_WAIT.

Reset
REQ-026 While rst_l = 1 at a clock edge: state IDLE, FIFO empty, Instruction = NOP, fpu_active = 0, fpu_timeout = 0, issue_count = 0, wait counter = 0, fetch_ready = 0.
REQ-027 Reset asserted mid-FPU_WAIT SHALL discard the in-flight word and all buffered words; no pulse on fpu_timeout.
REQ-028 fetch_ready SHALL go 1 on the first clock after rst_l deasserts.

Structure
REQ-029 Shared package SHALL hold FP/CSR opcode constants, NOP word, FIFO depth (4), timeout limit (255) and the FSM state enumeration.
REQ-030 The FIFO SHALL be a sub-module fpu_issue_fifo (parameterised depth/width, outputs full, empty, head word); FSM and counters stay in fpu_issue_seq.

Verification
REQ-031 Push 32'h00500093 (ADDI) then 32'h00000013 -> each on Instruction one cycle, issue_count = 2, fpu_active never 1.
REQ-032 Push 32'h002081D3 (FADD), fpu_complete after 5 cycles -> Instruction held 6 cycles, fpu_active = 1 throughout, then next word issues.
REQ-033 Push FADD, never assert fpu_complete -> fpu_timeout pulses once after 255 wait cycles, fpu_active then 0.
REQ-034 Push 32'h00202073 (CSRRS) then ADDI -> CSR word one cycle, NOP one cycle, then ADDI.
REQ-035 Fill 4 words with halt_req = 1 -> fetch_ready = 0, Instruction = NOP; release halt -> 4 words issue back-to-back while a 5th push succeeds same cycle as first pop.
REQ-036 Assert rst_l during FPU_WAIT with 3 words buffered -> next cycle all outputs at REQ-026 values, no stale word issued after release.

Source files
------------

// File: rtl/fpu_issue_seq_pkg.sv
// ----------------------------------------------------------------------------
// fpu_issue_seq_pkg
// Shared constants and types for the FP-aware issue sequencer:
//   - instruction width, NOP encoding
//   - issue FIFO depth and occupancy counter width
//   - FP wait timeout limit
//   - FP / CSR major-opcode constants and classification helpers
//   - sequencer FSM state enumeration
// ----------------------------------------------------------------------------
package fpu_issue_seq_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [INSTR_W-1:0] NOP_WORD      = 32'h0000_0013;
    localparam logic [7:0]         TIMEOUT_LIMIT = 8'd255;

    // Major opcodes (instr[6:0]) that route to the FPU.
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_FMADD    = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    // SYSTEM opcode carries the CSR access instructions.
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_FPU_WAIT,
        ST_CSR_GAP,
        ST_HALT
    } state_e;

    function automatic logic is_fp_instr(input logic [INSTR_W-1:0] word);
        logic fp;
        fp = 1'b0;
        case (word[6:0])
            OPC_LOAD_FP, OPC_STORE_FP, OPC_FMADD, OPC_FMSUB,
            OPC_FNMSUB, OPC_FNMADD, OPC_OP_FP: fp = 1'b1;
            default:                          fp = 1'b0;
        endcase
        return fp;
    endfunction

    function automatic logic is_csr_instr(input logic [INSTR_W-1:0] word);
        return (word[6:0] == OPC_SYSTEM);
    endfunction

endpackage : fpu_issue_seq_pkg

// File: rtl/fpu_issue_fifo.sv
// ----------------------------------------------------------------------------
// fpu_issue_fifo
// Small synchronous FIFO buffering fetched instruction words.
// Ports:
//   clk       - clock, rising edge
//   rst_l     - synchronous active-high reset (empties the FIFO)
//   push_i    - write data_i this cycle
//   pop_i     - drop the head entry this cycle
//   data_i    - word to write
//   data_o    - current head word (valid when empty_o = 0)
//   full_o    - FIFO holds DEPTH words
//   empty_o   - FIFO holds no words
//   count_o   - current occupancy
// DEPTH must be a power of two; pointers carry one extra wrap bit so that
// full and empty are distinguishable when the index bits match.
// ----------------------------------------------------------------------------
module fpu_issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle, so occupancy never exceeds DEPTH.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are meaningful, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule : fpu_issue_fifo

// File: rtl/fpu_issue_seq.sv
// ----------------------------------------------------------------------------
// fpu_issue_seq
// Issue sequencer between fetch and decode. Buffers fetched words, presents
// one word per ISSUE cycle, holds FP instructions until the FPU completes
// (or decode rejects them, or a wait timeout fires), inserts a one-cycle NOP
// gap after CSR accesses, and honours decode halt requests.
// Ports:
//   clk            - clock, rising edge
//   rst_l          - synchronous active-high reset
//   fetch_instr    - instruction word from fetch
//   fetch_valid    - fetch_instr valid; pushed when fetch_valid & fetch_ready
//   fetch_ready    - buffer can accept one word this cycle
//   Instruction    - word presented to decode (NOP when nothing is issued)
//   fpu_active     - presented word is an FP instruction waiting on the FPU
//   fpu_complete   - FPU finished current FP instruction (FPU_WAIT only)
//   halt_req       - decode requests an issue pause
//   illegal_config - decode rejected the current FP instruction
//   fpu_timeout    - one-cycle pulse after an FP wait is abandoned
//   issue_count    - number of words issued, wraps modulo 2^16
// ----------------------------------------------------------------------------
module fpu_issue_seq
    import fpu_issue_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_l,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    output logic [INSTR_W-1:0] Instruction,
    output logic               fpu_active,
    input  logic               fpu_complete,
    input  logic               halt_req,
    input  logic               illegal_config,
    output logic               fpu_timeout,
    output logic [15:0]        issue_count
);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   hold_q, hold_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic [15:0]          issue_cnt_q, issue_cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 ready_en_q;

    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [INSTR_W-1:0]   fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                 avail_next;
    state_e               resume_state;

    // The head is consumed in every ISSUE cycle; ISSUE is only entered when
    // a word will be present.
    assign pop  = (state_q == ST_ISSUE);
    // ready_en_q keeps the buffer closed during reset and opens it on the
    // first edge after release. A full buffer still accepts a word while
    // its head is being popped.
    assign fetch_ready = ready_en_q && (!fifo_full || pop);
    assign push        = fetch_valid && fetch_ready;

    // FIFO holds at least one word after this edge.
    assign avail_next = push ||
                        ((fifo_count != '0) &&
                         !(pop && (fifo_count == FIFO_CNT_W'(1))));
    assign resume_state = avail_next ? ST_ISSUE : ST_IDLE;

    fpu_issue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (fetch_instr),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst_l) begin
            state_q     <= ST_IDLE;
            hold_q      <= NOP_WORD;
            wait_cnt_q  <= '0;
            issue_cnt_q <= '0;
            timeout_q   <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            wait_cnt_q  <= wait_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            timeout_q   <= timeout_d;
            ready_en_q  <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // through the case statement can leave a signal unassigned (latch).
        state_d     = state_q;
        hold_d      = hold_q;
        wait_cnt_d  = wait_cnt_q;
        issue_cnt_d = issue_cnt_q;
        timeout_d   = 1'b0;
        Instruction = NOP_WORD;
        fpu_active  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (halt_req)         state_d = ST_HALT;
                else if (!fifo_empty) state_d = ST_ISSUE;
            end

            ST_ISSUE: begin
                Instruction = fifo_head;
                issue_cnt_d = issue_cnt_q + 16'd1;
                if (is_fp_instr(fifo_head)) begin
                    state_d    = ST_FPU_WAIT;
                    hold_d     = fifo_head;
                    wait_cnt_d = '0;
                end else if (is_csr_instr(fifo_head)) begin
                    state_d = ST_CSR_GAP;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = resume_state;
                end
            end

            ST_FPU_WAIT: begin
                Instruction = hold_q;
                fpu_active  = 1'b1;
                // A rejected instruction and a completed one leave the same
                // way; only an unanswered wait raises the timeout pulse.
                if (illegal_config || fpu_complete) begin
                    state_d = resume_state;
                end else if (wait_cnt_q == TIMEOUT_LIMIT) begin
                    state_d   = resume_state;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            ST_CSR_GAP: begin
                // One bubble so the registered CSR read-back settles before
                // the next word reaches decode.
                state_d = resume_state;
            end

            ST_HALT: begin
                if (!halt_req) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign fpu_timeout = timeout_q;
    assign issue_count = issue_cnt_q;

endmodule : fpu_issue_seq

// File: tb/tb_fpu_issue_seq.sv
// ----------------------------------------------------------------------------
// tb_fpu_issue_seq
// Directed self-checking bench for fpu_issue_seq. Inputs change and outputs
// are sampled on the falling clock edge; expected values are hand-derived.
// ----------------------------------------------------------------------------
module tb_fpu_issue_seq;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] FADD  = 32'h0020_81D3;
    localparam logic [31:0] CSRRS = 32'h0020_2073;
    localparam logic [31:0] W0    = 32'h0010_0093;
    localparam logic [31:0] W1    = 32'h0020_0113;
    localparam logic [31:0] W2    = 32'h0030_0193;
    localparam logic [31:0] W3    = 32'h0040_0213;
    localparam logic [31:0] W4    = 32'h0060_0293;
    localparam logic [31:0] ADDI7 = 32'h0070_0093;

    logic        clk;
    logic        rst_l;
    logic [31:0] fetch_instr;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] Instruction;
    logic        fpu_active;
    logic        fpu_complete;
    logic        halt_req;
    logic        illegal_config;
    logic        fpu_timeout;
    logic [15:0] issue_count;

    int compared   = 0;
    int mismatched = 0;

    fpu_issue_seq dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .fetch_instr    (fetch_instr),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .Instruction    (Instruction),
        .fpu_active     (fpu_active),
        .fpu_complete   (fpu_complete),
        .halt_req       (halt_req),
        .illegal_config (illegal_config),
        .fpu_timeout    (fpu_timeout),
        .issue_count    (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one word for exactly one cycle once the buffer is ready.
    task automatic push(input logic [31:0] w);
        int guard;
        guard = 0;
        while (fetch_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        check("push_ready", 32'(fetch_ready), 32'd1);
        fetch_valid = 1'b1;
        fetch_instr = w;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic wait_instr(input string tag, input logic [31:0] w);
        int guard;
        guard = 0;
        while (Instruction !== w && guard < 20) begin
            tick();
            guard++;
        end
        check(tag, Instruction, w);
    endtask

    initial begin : stim
        int n;
        int early;

        rst_l          = 1'b1;
        fetch_instr    = '0;
        fetch_valid    = 1'b0;
        fpu_complete   = 1'b0;
        halt_req       = 1'b0;
        illegal_config = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_instr",   Instruction,           NOP);
        check("rst_ready",   32'(fetch_ready),      32'd0);
        check("rst_active",  32'(fpu_active),       32'd0);
        check("rst_timeout", 32'(fpu_timeout),      32'd0);
        check("rst_count",   32'(issue_count),      32'd0);
        rst_l = 1'b0;
        tick();
        check("rel_ready",   32'(fetch_ready),      32'd1);
        check("rel_instr",   Instruction,           NOP);

        // ---------------- two integer words ----------------
        push(ADDI);
        push(NOP);
        wait_instr("int_addi", ADDI);
        check("int_active0", 32'(fpu_active), 32'd0);
        check("int_count0",  32'(issue_count), 32'd0);
        tick();
        check("int_nop",     Instruction,      NOP);
        check("int_count1",  32'(issue_count), 32'd1);
        check("int_active1", 32'(fpu_active),  32'd0);
        tick();
        check("int_count2",  32'(issue_count), 32'd2);
        check("int_active2", 32'(fpu_active),  32'd0);

        // ---------------- FADD completing after 5 wait cycles ----------------
        push(FADD);
        push(ADDI);
        wait_instr("fadd_issue", FADD);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("fadd_hold",   Instruction,     FADD);
            check("fadd_active", 32'(fpu_active), 32'd1);
            if (i == 5) fpu_complete = 1'b1;
        end
        tick();
        fpu_complete = 1'b0;
        check("fadd_next",     Instruction,      ADDI);
        check("fadd_inactive", 32'(fpu_active),  32'd0);
        tick();
        check("fadd_idle",     Instruction,      NOP);
        check("fadd_count",    32'(issue_count), 32'd4);

        // ---------------- FADD timeout ----------------
        // A completion outside FPU_WAIT must not shorten the next wait.
        fpu_complete = 1'b1;
        tick();
        fpu_complete = 1'b0;
        push(FADD);
        wait_instr("to_issue", FADD);
        tick();
        n = 0;
        early = 0;
        while (fpu_active === 1'b1 && n < 300) begin
            n++;
            if (fpu_timeout !== 1'b0) early++;
            tick();
        end
        check("to_wait_cycles", 32'(n),            32'd256);
        check("to_no_early",    32'(early),        32'd0);
        check("to_pulse",       32'(fpu_timeout),  32'd1);
        check("to_active_drop", 32'(fpu_active),   32'd0);
        check("to_instr",       Instruction,       NOP);
        tick();
        check("to_pulse_end",   32'(fpu_timeout),  32'd0);
        check("to_count",       32'(issue_count),  32'd5);

        // ---------------- illegal_config abort ----------------
        push(FADD);
        wait_instr("ill_issue", FADD);
        illegal_config = 1'b1;
        tick();
        check("ill_wait_active", 32'(fpu_active), 32'd1);
        check("ill_wait_instr",  Instruction,     FADD);
        tick();
        illegal_config = 1'b0;
        check("ill_exit_active", 32'(fpu_active),  32'd0);
        check("ill_no_timeout",  32'(fpu_timeout), 32'd0);
        check("ill_exit_instr",  Instruction,      NOP);
        check("ill_count",       32'(issue_count), 32'd6);

        // ---------------- CSR gap ----------------
        push(CSRRS);
        push(ADDI);
        wait_instr("csr_issue", CSRRS);
        tick();
        check("csr_gap",        Instruction,      NOP);
        check("csr_gap_active", 32'(fpu_active),  32'd0);
        tick();
        check("csr_next",       Instruction,      ADDI);
        tick();
        check("csr_count",      32'(issue_count), 32'd8);

        // ---------------- halt with full buffer ----------------
        halt_req = 1'b1;
        push(W0);
        push(W1);
        push(W2);
        push(W3);
        check("halt_full_ready", 32'(fetch_ready), 32'd0);
        check("halt_instr",      Instruction,      NOP);
        tick();
        check("halt_hold_instr", Instruction,      NOP);
        check("halt_count",      32'(issue_count), 32'd8);
        halt_req    = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = W4;
        tick();
        check("halt_w0",         Instruction,      W0);
        check("halt_popready",   32'(fetch_ready), 32'd1);
        tick();
        fetch_valid = 1'b0;
        check("halt_w1", Instruction, W1);
        tick();
        check("halt_w2", Instruction, W2);
        tick();
        check("halt_w3", Instruction, W3);
        tick();
        check("halt_w4", Instruction, W4);
        tick();
        check("halt_end_instr", Instruction,      NOP);
        check("halt_end_count", 32'(issue_count), 32'd13);

        // ---------------- reset during FPU_WAIT ----------------
        push(FADD);
        push(W1);
        push(W2);
        push(W3);
        check("mid_active", 32'(fpu_active), 32'd1);
        check("mid_instr",  Instruction,     FADD);
        rst_l = 1'b1;
        tick();
        check("mrst_instr",   Instruction,          NOP);
        check("mrst_active",  32'(fpu_active),      32'd0);
        check("mrst_timeout", 32'(fpu_timeout),     32'd0);
        check("mrst_count",   32'(issue_count),     32'd0);
        check("mrst_ready",   32'(fetch_ready),     32'd0);
        rst_l = 1'b0;
        tick();
        check("mrel_ready",   32'(fetch_ready),     32'd1);
        for (int i = 0; i < 3; i++) begin
            check("mrel_nop",   Instruction,      NOP);
            check("mrel_count", 32'(issue_count), 32'd0);
            tick();
        end
        push(ADDI7);
        wait_instr("mrel_fresh", ADDI7);
        tick();
        check("mrel_fresh_count", 32'(issue_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fpu_issue_seq
